// File: rtl/prosparsity_pkg.sv
// prosparsity_pkg: shared state encoding, width helper and prefix convention for the ProSparsity pruning unit
package prosparsity_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SEARCH = 2'd1;
   localparam logic [1:0] ST_EMIT   = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      SEARCH = ST_SEARCH,
      EMIT   = ST_EMIT,
      DONE   = ST_DONE
   } state_e;

   // A row whose prefix id equals its own index has no prefix; dispatcher and processor rely on this.
   localparam bit NO_PREFIX_IS_SELF = 1'b1;

   // Index width for a table of n entries, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/prosparsity_row_pruner_if.sv
// prosparsity_row_pruner_if: spike-row input and row-info output handshakes of the pruner
interface prosparsity_row_pruner_if #(
   parameter int PATTERN_WIDTH = 16,
   parameter int IDX_W         = 8,
   parameter int NO_WIDTH      = 8
);
   logic                     spk_valid;
   logic                     spk_ready;
   logic [PATTERN_WIDTH-1:0] spk_pattern;
   logic                     spk_last;
   logic                     row_info_valid;
   logic                     row_info_ready;
   logic [IDX_W-1:0]         row_idx;
   logic [IDX_W-1:0]         row_prefix_id;
   logic [PATTERN_WIDTH-1:0] row_pattern;
   logic [NO_WIDTH-1:0]      row_popcnt;
   logic                     row_last;
   logic                     pruner_done;

   modport master (
      input  spk_valid, spk_pattern, spk_last, row_info_ready,
      output spk_ready, row_info_valid, row_idx, row_prefix_id, row_pattern,
             row_popcnt, row_last, pruner_done
   );

   modport slave (
      output spk_valid, spk_pattern, spk_last, row_info_ready,
      input  spk_ready, row_info_valid, row_idx, row_prefix_id, row_pattern,
             row_popcnt, row_last, pruner_done
   );
endinterface

// File: rtl/prosparsity_row_pruner_popcount.sv
// spike_popcount: combinational count of set spikes in a row pattern
module spike_popcount #(
   parameter int PATTERN_WIDTH = 16,
   parameter int NO_WIDTH      = 8
) (
   input  logic [PATTERN_WIDTH-1:0] pattern,
   output logic [NO_WIDTH-1:0]      popcnt
);

   // accumulate one bit at a time
   always_comb begin
      popcnt = '0;
      for (int i = 0; i < PATTERN_WIDTH; i++) popcnt = popcnt + NO_WIDTH'(pattern[i]);
   end

endmodule

// File: rtl/prosparsity_row_pruner.sv
// prosparsity_row_pruner: picks, for each row of a spike tile, the largest-popcount earlier subset row as its prefix
module prosparsity_row_pruner
   import prosparsity_pkg::*;
#(
   parameter int ROWS          = 256,
   parameter int SPIKES        = 16,
   parameter int PATTERN_WIDTH = SPIKES,
   parameter int NO_WIDTH      = 8
) (
   input logic                     clk,
   input logic                     rst_n,
   prosparsity_row_pruner_if.master bus
);

   localparam int IDX_W = idx_width(ROWS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

   state_e                   state_q, state_d;
   logic [IDX_W-1:0]         cur_idx_q, cur_idx_d;
   logic [PATTERN_WIDTH-1:0] cur_pat_q, cur_pat_d;
   logic [NO_WIDTH-1:0]      cur_pc_q, cur_pc_d;
   logic                     cur_last_q, cur_last_d;
   logic [NO_WIDTH-1:0]      best_pc_q, best_pc_d;
   logic [IDX_W-1:0]         best_id_q, best_id_d;
   logic [IDX_W-1:0]         scan_q, scan_d;
   logic [PATTERN_WIDTH-1:0] pat_q [ROWS];
   logic [PATTERN_WIDTH-1:0] pat_d [ROWS];
   logic [NO_WIDTH-1:0]      pc_q [ROWS];
   logic [NO_WIDTH-1:0]      pc_d [ROWS];
   logic [ROWS-1:0]          vld_q, vld_d;
   logic [NO_WIDTH-1:0]      in_pc;
   logic                     cand;
   logic                     emit;

   spike_popcount #(.PATTERN_WIDTH(PATTERN_WIDTH), .NO_WIDTH(NO_WIDTH)) u_popcount (
      .pattern (bus.spk_pattern),
      .popcnt  (in_pc)
   );

   assign cand = vld_q[scan_q] && ((pat_q[scan_q] & ~cur_pat_q) == '0) && (pc_q[scan_q] > best_pc_q);
   assign emit = (state_q == EMIT);

   assign bus.spk_ready      = rst_n && (state_q == IDLE);
   assign bus.row_info_valid = emit;
   assign bus.row_idx        = emit ? cur_idx_q : '0;
   assign bus.row_prefix_id  = emit ? best_id_q : '0;
   assign bus.row_pattern    = emit ? cur_pat_q : '0;
   assign bus.row_popcnt     = emit ? cur_pc_q : '0;
   assign bus.row_last       = emit && cur_last_q;
   assign bus.pruner_done    = (state_q == DONE);

   // next-state: accept a row, scan earlier entries one per cycle, hold the record until taken
   always_comb begin
      state_d    = state_q;
      cur_idx_d  = cur_idx_q;
      cur_pat_d  = cur_pat_q;
      cur_pc_d   = cur_pc_q;
      cur_last_d = cur_last_q;
      best_pc_d  = best_pc_q;
      best_id_d  = best_id_q;
      scan_d     = scan_q;
      pat_d      = pat_q;
      pc_d       = pc_q;
      vld_d      = vld_q;
      case (state_q)
         IDLE: begin
            if (bus.spk_valid) begin
               pat_d[cur_idx_q] = bus.spk_pattern;
               pc_d[cur_idx_q]  = in_pc;
               vld_d[cur_idx_q] = 1'b1;
               cur_pat_d        = bus.spk_pattern;
               cur_pc_d         = in_pc;
               cur_last_d       = bus.spk_last || (cur_idx_q == LAST_IDX);
               best_pc_d        = '0;
               best_id_d        = cur_idx_q;
               scan_d           = '0;
               state_d          = SEARCH;
            end
         end
         SEARCH: begin
            if (scan_q == cur_idx_q) begin
               state_d = EMIT;
            end else begin
               best_pc_d = cand ? pc_q[scan_q] : best_pc_q;
               best_id_d = cand ? scan_q : best_id_q;
               scan_d    = scan_q + IDX_W'(1);
            end
         end
         EMIT: begin
            if (bus.row_info_ready) begin
               vld_d     = cur_last_q ? '0 : vld_q;
               cur_idx_d = cur_last_q ? '0 : cur_idx_q + IDX_W'(1);
               state_d   = cur_last_q ? DONE : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state and table registers, cleared asynchronously so reset abandons any row in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cur_idx_q  <= '0;
         cur_pat_q  <= '0;
         cur_pc_q   <= '0;
         cur_last_q <= 1'b0;
         best_pc_q  <= '0;
         best_id_q  <= '0;
         scan_q     <= '0;
         vld_q      <= '0;
         for (int i = 0; i < ROWS; i++) begin
            pat_q[i] <= '0;
            pc_q[i]  <= '0;
         end
      end else begin
         state_q    <= state_d;
         cur_idx_q  <= cur_idx_d;
         cur_pat_q  <= cur_pat_d;
         cur_pc_q   <= cur_pc_d;
         cur_last_q <= cur_last_d;
         best_pc_q  <= best_pc_d;
         best_id_q  <= best_id_d;
         scan_q     <= scan_d;
         vld_q      <= vld_d;
         pat_q      <= pat_d;
         pc_q       <= pc_d;
      end
   end

endmodule

// File: tb/tb_prosparsity_row_pruner.sv
// tb_prosparsity_row_pruner: directed and random tiles checked against a subset/popcount reference model
module tb_prosparsity_row_pruner;

   localparam int ROWS = 8;
   localparam int PW   = 4;
   localparam int NW   = 8;
   localparam int IW   = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   logic [PW-1:0] tile [$];

   prosparsity_row_pruner_if #(.PATTERN_WIDTH(PW), .IDX_W(IW), .NO_WIDTH(NW)) bus ();

   prosparsity_row_pruner #(.ROWS(ROWS), .SPIKES(PW), .PATTERN_WIDTH(PW), .NO_WIDTH(NW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_fields(input int r, input int best, input logic [PW-1:0] p, input bit xlast);
      chk("info_valid", 32'(bus.row_info_valid), 1);
      chk("row_idx", 32'(bus.row_idx), 32'(r));
      chk("row_prefix_id", 32'(bus.row_prefix_id), 32'(best));
      chk("row_pattern", 32'(bus.row_pattern), 32'(p));
      chk("row_popcnt", 32'(bus.row_popcnt), 32'($countones(p)));
      chk("row_last", 32'(bus.row_last), 32'(xlast));
      chk("spk_ready_emit", 32'(bus.spk_ready), 0);
      chk("done_emit", 32'(bus.pruner_done), 0);
   endtask

   // Drive one row, predict its record from the rows seen so far in this tile, and take the record.
   task automatic send_row(input logic [PW-1:0] p, input bit last, input int hold);
      int r, lat, best, bpc;
      bit xlast;
      r = tile.size();
      best = r;
      bpc = 0;
      foreach (tile[i])
         if (((tile[i] & ~p) == '0) && ($countones(tile[i]) > bpc)) begin
            bpc  = $countones(tile[i]);
            best = i;
         end
      xlast = last || (r == ROWS - 1);
      chk("spk_ready_idle", 32'(bus.spk_ready), 1);
      bus.spk_valid      = 1'b1;
      bus.spk_pattern    = p;
      bus.spk_last       = last;
      bus.row_info_ready = (hold == 0);
      @(negedge clk);
      bus.spk_valid   = 1'b0;
      bus.spk_pattern = '0;
      bus.spk_last    = 1'b0;
      tile.push_back(p);
      lat = 0;
      while (bus.row_info_valid !== 1'b1 && lat < 40) begin
         chk("spk_ready_busy", 32'(bus.spk_ready), 0);
         @(negedge clk);
         lat++;
      end
      chk("latency", 32'(lat), 32'(r + 1));
      for (int c = 0; c < hold; c++) begin
         check_fields(r, best, p, xlast);
         @(negedge clk);
      end
      check_fields(r, best, p, xlast);
      bus.row_info_ready = 1'b1;
      @(negedge clk);
      chk("valid_drop", 32'(bus.row_info_valid), 0);
      chk("pruner_done", 32'(bus.pruner_done), 32'(xlast));
      if (xlast) begin
         tile.delete();
         @(negedge clk);
         chk("done_one_cycle", 32'(bus.pruner_done), 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.spk_valid      = 1'b0;
      bus.spk_pattern    = '0;
      bus.spk_last       = 1'b0;
      bus.row_info_ready = 1'b1;
      rst_n              = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_spk_ready", 32'(bus.spk_ready), 0);
      chk("rst_valid", 32'(bus.row_info_valid), 0);
      chk("rst_done", 32'(bus.pruner_done), 0);
      chk("rst_row_last", 32'(bus.row_last), 0);
      chk("rst_row_idx", 32'(bus.row_idx), 0);
      chk("rst_row_pattern", 32'(bus.row_pattern), 0);
      rst_n = 1'b1;
      @(negedge clk);

      send_row(4'b0011, 1'b0, 0);
      send_row(4'b0111, 1'b0, 0);
      send_row(4'b0001, 1'b0, 0);
      send_row(4'b1111, 1'b1, 0);

      send_row(4'b0011, 1'b0, 0);
      send_row(4'b0101, 1'b0, 0);
      send_row(4'b0011, 1'b1, 0);

      send_row(4'b0001, 1'b0, 0);
      send_row(4'b0011, 1'b0, 0);
      send_row(4'b0000, 1'b0, 3);
      send_row(4'b1011, 1'b1, 10);

      for (int i = 0; i < ROWS; i++) send_row(4'b0001, 1'b0, 0);
      send_row(4'b0001, 1'b1, 0);

      for (int i = 0; i < 40; i++)
         send_row(PW'($urandom), (i == 39) || ($urandom_range(0, 5) == 0), int'($urandom_range(0, 3)));

      for (int i = 0; i < 5; i++) send_row(PW'($urandom), 1'b0, 0);
      bus.spk_valid   = 1'b1;
      bus.spk_pattern = 4'b0111;
      bus.spk_last    = 1'b0;
      @(negedge clk);
      bus.spk_valid = 1'b0;
      @(negedge clk);
      chk("search_busy", 32'(bus.row_info_valid), 0);
      rst_n = 1'b0;
      #1;
      chk("midrst_spk_ready", 32'(bus.spk_ready), 0);
      chk("midrst_valid", 32'(bus.row_info_valid), 0);
      chk("midrst_done", 32'(bus.pruner_done), 0);
      chk("midrst_row_idx", 32'(bus.row_idx), 0);
      chk("midrst_popcnt", 32'(bus.row_popcnt), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tile.delete();
      @(negedge clk);
      send_row(4'b0111, 1'b0, 0);
      send_row(4'b0011, 1'b1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
